gpioemu_result_buf: RTL and testbench
=====================================

GPIOEMU_RESULT_BUF -- requirements
Module: gpioemu_result_buf

Interface
REQ-001 Parameter DEPTH, default 4, number of result entries; the value SHALL be a power of two in the range 2..16.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset SHALL be synchronous and active-high.
REQ-004 W_in  input  32  product low word from the multiplier stage.
REQ-005 L_in  input  24  ones count from the multiplier stage.
REQ-006 B_in  input  2  status from the multiplier stage: bit1 = ready, bit0 = valid (product fits in 32 bits).
REQ-007 rd_en  input  1  pop request for the head entry.
REQ-008 clr_ovf  input  1  clears the overflow indication.
REQ-009 rd_w  output  32  W field of the head entry.
REQ-010 rd_l  output  24  L field of the head entry.
REQ-011 rd_fit  output  1  valid bit of the head entry.
REQ-012 empty  output  1  high when the buffer holds no entries.
REQ-013 full  output  1  high when the buffer holds DEPTH entries.
REQ-014 level  output  clog2(DEPTH)+1  current entry count.
REQ-015 ovf  output  1  sticky flag: at least one result has been dropped.
REQ-016 ovf_cnt  output  8  dropped-result counter; the port SHALL be present only with RESBUF_STATS_EN.

Function
REQ-017 Each entry SHALL store {W_in, L_in, B_in[0]}, 57 bits in total.
REQ-018 The block SHALL keep ready_q, a one-cycle delayed copy of B_in[1].
REQ-019 A completion event SHALL be B_in[1]==1 && ready_q==0, i.e. a rising edge of ready.
REQ-020 On a completion event, W_in, L_in and B_in[0] SHALL be sampled in the same cycle as the event.
REQ-021 A level of ready held high, such as upstream idling, SHALL NOT generate further events.
REQ-022 Capture latency: the entry SHALL be visible on rd_* and empty SHALL deassert on the cycle after the event.
REQ-023 The read side SHALL be first-word fall-through: rd_w, rd_l and rd_fit SHALL show the head entry whenever empty==0.
REQ-024 rd_w, rd_l and rd_fit SHALL be driven to 0 when empty==1.
REQ-025 rd_en with empty==0 SHALL pop the head entry; the next entry, or zeros, SHALL appear on the following cycle.
REQ-026 rd_en with empty==1 SHALL be ignored, with no pointer or level change.
REQ-027 A completion event with full==0 SHALL push the entry and increment level.
REQ-028 A completion event with full==1 and no pop SHALL discard the data, set ovf and leave the contents unchanged.
REQ-029 Simultaneous push and pop with full==1 SHALL perform both operations; level stays at DEPTH and ovf is unchanged.
REQ-030 Simultaneous push and pop with 0<level<DEPTH SHALL leave level unchanged.
REQ-031 A completion event together with rd_en while empty SHALL push only.
REQ-032 Read and write pointers SHALL wrap modulo DEPTH.
REQ-033 full SHALL equal (level==DEPTH), and empty SHALL equal (level==0).
REQ-034 clr_ovf SHALL clear ovf, and ovf_cnt when present, on the next edge.
REQ-035 If a drop occurs in the same cycle as clr_ovf, ovf SHALL be 1 afterwards and ovf_cnt SHALL be 1.

Reset
REQ-036 Reset SHALL set both pointers to 0, level to 0, empty to 1, full to 0, ovf to 0 and ovf_cnt to 0.
REQ-037 Reset SHALL force rd_w, rd_l and rd_fit to 0.
REQ-038 Reset SHALL set ready_q to 1, so an upstream stage idling with ready high produces no spurious capture.
REQ-039 Reset asserted mid-operation SHALL discard all stored entries and override any push, pop or clr_ovf in the same cycle.
REQ-040 Storage array contents need not be cleared by reset.

Configuration
REQ-041 Macro RESBUF_STATS_EN defined: the ovf_cnt port SHALL exist and increment by 1 per dropped result, saturating at 255.
REQ-042 Macro RESBUF_STATS_EN undefined: neither the ovf_cnt port nor its counter logic SHALL exist; ovf behaviour is unchanged.

Verification
REQ-043 Reset, then B_in held at 2'b11 for 10 cycles -> empty=1, level=0, no capture.
REQ-044 B_in[1] pulses 0->1 with W_in=32'h0000_0C35 and L_in=7 -> next cycle rd_w=32'h0000_0C35, rd_l=7, rd_fit=1, level=1; rd_en for one cycle -> empty=1 and rd_w=0.
REQ-045 Five events with W_in=1..5 and no reads, DEPTH=4 -> full=1, ovf=1, ovf_cnt=1 (macro on); four pops return 1, 2, 3, 4 in order.
REQ-046 With full=1, an event coincides with rd_en -> head 1 is popped, 5 is appended, level=4, ovf unchanged.
REQ-047 Push 3 and pop 3, then 6 more pushes with 2 pops -> pointer wrap preserves FIFO order and level=4; rd_en while empty -> no change.
REQ-048 Reset asserted while level=3 and ovf=1 -> next cycle level=0, empty=1, ovf=0 and all rd_* outputs are 0.

Source files
------------

// File: rtl/gpioemu_result_buf.sv
`default_nettype none
// ============================================================================
//  Module   : gpioemu_result_buf
//  Purpose  : Result FIFO behind the multiplier stage. A rising edge on the
//             ready bit (B_in[1]) captures {W_in, L_in, B_in[0]} into a
//             DEPTH-entry first-word-fall-through buffer. Results arriving
//             while the buffer is full are dropped and flagged on a sticky
//             overflow flag.
//  Options  : RESBUF_STATS_EN - adds the ovf_cnt port, an 8-bit saturating
//             count of dropped results. It is absent when the macro is
//             undefined.
//  Ports    : clk      - clock, rising edge
//             reset    - synchronous active-high reset
//             W_in     - product low word (32)
//             L_in     - ones count (24)
//             B_in     - {ready, fits-in-32-bits}
//             rd_en    - pop the head entry
//             clr_ovf  - clear overflow flag / counter
//             rd_w, rd_l, rd_fit - head entry fields, zero when empty
//             empty, full, level - occupancy status
//             ovf      - sticky drop flag
//             ovf_cnt  - drop counter (RESBUF_STATS_EN only)
//  Revision : 1.0 - initial release
// ============================================================================
module gpioemu_result_buf #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                W_in,
  input  logic [23:0]                L_in,
  input  logic [1:0]                 B_in,
  input  logic                       rd_en,
  input  logic                       clr_ovf,
  output logic [31:0]                rd_w,
  output logic [23:0]                rd_l,
  output logic                       rd_fit,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf
`ifdef RESBUF_STATS_EN
  ,
  output logic [7:0]                 ovf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 57;
  localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);

  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("gpioemu_result_buf: DEPTH must be a power of two in 2..16");
  end

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [LW-1:0] r_level;
  logic          r_ready_q;
  logic          r_ovf;

  logic          w_evt;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [EW-1:0] w_head;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == C_DEPTH);

  // Only the rising edge of ready is a completion; a held-high ready is idle.
  assign w_evt  = B_in[1] & ~r_ready_q;
  assign w_pop  = rd_en & ~w_empty;
  // When full, a simultaneous pop frees the slot this push will use.
  assign w_push = w_evt & (~w_full | w_pop);
  assign w_drop = w_evt & w_full & ~w_pop;

  assign w_head = r_mem[r_rp];

  // Storage is not reset; pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wp] <= {W_in, L_in, B_in[0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_level   <= '0;
      r_ready_q <= 1'b1;
      r_ovf     <= 1'b0;
    end else begin
      r_ready_q <= B_in[1];
      if (w_push) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      // A drop in the same cycle as a clear wins, so it is never lost.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef RESBUF_STATS_EN
  logic [7:0] r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf_cnt <= '0;
    end else if (clr_ovf) begin
      r_ovf_cnt <= w_drop ? 8'd1 : 8'd0;
    end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

  assign empty  = w_empty;
  assign full   = w_full;
  assign level  = r_level;
  assign ovf    = r_ovf;
  assign rd_w   = w_empty ? 32'd0 : w_head[56:25];
  assign rd_l   = w_empty ? 24'd0 : w_head[24:1];
  assign rd_fit = w_empty ? 1'b0  : w_head[0];

endmodule
`default_nettype wire

// File: tb/tb_gpioemu_result_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpioemu_result_buf
//  Purpose  : Self-checking bench for gpioemu_result_buf. A queue holds the
//             entries the buffer should contain; captures push to it and pops
//             compare the DUT head against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpioemu_result_buf;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] W_in;
  logic [23:0] L_in;
  logic [1:0]  B_in;
  logic        rd_en;
  logic        clr_ovf;
  logic [31:0] rd_w;
  logic [23:0] rd_l;
  logic        rd_fit;
  logic        empty;
  logic        full;
  logic [2:0]  level;
  logic        ovf;
`ifdef RESBUF_STATS_EN
  logic [7:0]  ovf_cnt;
`endif

  gpioemu_result_buf #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .W_in    (W_in),
    .L_in    (L_in),
    .B_in    (B_in),
    .rd_en   (rd_en),
    .clr_ovf (clr_ovf),
    .rd_w    (rd_w),
    .rd_l    (rd_l),
    .rd_fit  (rd_fit),
    .empty   (empty),
    .full    (full),
    .level   (level),
    .ovf     (ovf)
`ifdef RESBUF_STATS_EN
    ,
    .ovf_cnt (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [56:0] r_sb [$];
  bit          r_m_rq;
  bit          r_m_ovf;
  int          r_m_cnt;
  int          r_n_vec;
  int          r_n_err;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    r_n_vec++;
    if (act !== exp) begin
      r_n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at a negedge: apply inputs, update the model, advance one cycle.
  task automatic drive(input logic [1:0] b, input logic [31:0] w, input logic [23:0] l,
                       input logic rd, input logic clr);
    bit evt, was_full, pop;
    B_in = b; W_in = w; L_in = l; rd_en = rd; clr_ovf = clr;
    evt      = b[1] && !r_m_rq;
    was_full = (r_sb.size() == DEPTH);
    pop      = rd && (r_sb.size() != 0);
    if (pop) begin
      check("pop_head", {7'd0, rd_w, rd_l, rd_fit}, {7'd0, r_sb[0]});
      void'(r_sb.pop_front());
    end
    if (evt && (!was_full || pop)) begin
      r_sb.push_back({w, l, b[0]});
    end
    if (evt && was_full && !pop) begin
      r_m_ovf = 1'b1;
      r_m_cnt = clr ? 1 : ((r_m_cnt < 255) ? r_m_cnt + 1 : 255);
    end else if (clr) begin
      r_m_ovf = 1'b0;
      r_m_cnt = 0;
    end
    r_m_rq = b[1];
    @(negedge clk);
  endtask

  // One completion: ready low for a cycle, then high with the data.
  task automatic event_pulse(input logic [31:0] w, input logic [23:0] l, input logic fit,
                             input logic rd, input logic clr);
    drive(2'b00, 32'd0, 24'd0, 1'b0, 1'b0);
    drive({1'b1, fit}, w, l, rd, clr);
  endtask

  task automatic pop1();
    drive(2'b11, 32'd0, 24'd0, 1'b1, 1'b0);
  endtask

  task automatic check_state(input string tag);
    logic [56:0] head;
    head = (r_sb.size() != 0) ? r_sb[0] : 57'd0;
    check({tag, "_empty"}, {63'd0, empty}, {63'd0, r_sb.size() == 0});
    check({tag, "_full"},  {63'd0, full},  {63'd0, r_sb.size() == DEPTH});
    check({tag, "_level"}, {61'd0, level}, 64'(r_sb.size()));
    check({tag, "_ovf"},   {63'd0, ovf},   {63'd0, r_m_ovf});
`ifdef RESBUF_STATS_EN
    check({tag, "_cnt"},   {56'd0, ovf_cnt}, 64'(r_m_cnt));
`endif
    check({tag, "_head"},  {7'd0, rd_w, rd_l, rd_fit}, {7'd0, head});
  endtask

  task automatic model_reset();
    r_sb.delete();
    r_m_rq  = 1'b1;
    r_m_ovf = 1'b0;
    r_m_cnt = 0;
  endtask

  initial begin
    r_n_vec = 0;
    r_n_err = 0;
    reset = 1'b1; W_in = '0; L_in = '0; B_in = 2'b11; rd_en = 1'b0; clr_ovf = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_state("reset");

    // Ready held high after reset: no captures.
    for (int i = 0; i < 10; i++) drive(2'b11, 32'hDEAD_0000 + 32'(i), 24'(i), 1'b0, 1'b0);
    check_state("idle_high");
    check("idle_level", {61'd0, level}, 64'd0);

    // Single capture, visible the following cycle, then popped.
    event_pulse(32'h0000_0C35, 24'd7, 1'b1, 1'b0, 1'b0);
    check("cap_w",   {32'd0, rd_w},   64'h0000_0C35);
    check("cap_l",   {40'd0, rd_l},   64'd7);
    check("cap_fit", {63'd0, rd_fit}, 64'd1);
    check("cap_lvl", {61'd0, level},  64'd1);
    pop1();
    check("pop_empty", {63'd0, empty}, 64'd1);
    check("pop_w0",    {32'd0, rd_w},  64'd0);

    // Five captures into four slots: the fifth is dropped.
    for (int i = 1; i <= 5; i++) event_pulse(32'(i), 24'(i * 3), 1'(i), 1'b0, 1'b0);
    check("ovf_full", {63'd0, full}, 64'd1);
    check("ovf_flag", {63'd0, ovf},  64'd1);
`ifdef RESBUF_STATS_EN
    check("ovf_cnt1", {56'd0, ovf_cnt}, 64'd1);
`endif
    check_state("after_drop");
    for (int i = 1; i <= 4; i++) begin
      check("order_w", {32'd0, rd_w}, 64'(i));
      pop1();
    end
    check_state("drained");

    // Full with simultaneous push and pop.
    for (int i = 1; i <= 4; i++) event_pulse(32'(i), 24'(i), 1'b0, 1'b0, 1'b0);
    event_pulse(32'd5, 24'd5, 1'b1, 1'b1, 1'b0);
    check("pp_level", {61'd0, level}, 64'd4);
    check("pp_ovf",   {63'd0, ovf},   64'd1);
    check("pp_head",  {32'd0, rd_w},  64'd2);
    check_state("pushpop_full");
    drive(2'b11, 32'd0, 24'd0, 1'b0, 1'b1);
    check_state("clr");
    // Drop and clear in the same cycle.
    event_pulse(32'd9, 24'd9, 1'b1, 1'b0, 1'b1);
    check("dropclr_ovf", {63'd0, ovf}, 64'd1);
    check_state("dropclr");
    while (r_sb.size() != 0) pop1();
    check_state("drained2");

    // Pointer wrap with mixed traffic.
    for (int i = 0; i < 3; i++) event_pulse($urandom, 24'($urandom), 1'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) pop1();
    for (int i = 0; i < 6; i++) event_pulse($urandom, 24'($urandom), 1'($urandom), 1'(i % 3 == 2), 1'b0);
    check("wrap_level", {61'd0, level}, 64'd4);
    check_state("wrap");
    while (r_sb.size() != 0) pop1();
    pop1();
    check_state("rd_empty");

    // Drop counter saturation.
    drive(2'b11, 32'd0, 24'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) event_pulse(32'(100 + i), 24'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) event_pulse(32'hFFFF_0000, 24'd1, 1'b1, 1'b0, 1'b0);
    check_state("saturate");

    // Reset mid-operation overrides push, pop and clear.
    pop1();
    check("pre_rst_level", {61'd0, level}, 64'd3);
    check("pre_rst_ovf",   {63'd0, ovf},   64'd1);
    reset = 1'b1; B_in = 2'b10; W_in = 32'h1234_5678; rd_en = 1'b1; clr_ovf = 1'b1;
    @(negedge clk);
    reset = 1'b0; B_in = 2'b11; rd_en = 1'b0; clr_ovf = 1'b0;
    model_reset();
    check_state("mid_reset");
    drive(2'b11, 32'h5555_5555, 24'd1, 1'b0, 1'b0);
    check_state("post_reset_idle");

    $display("== %0d vectors applied, %0d miscompares ==", r_n_vec, r_n_err);
    $finish;
  end

endmodule
`default_nettype wire
